// File: rtl/prvp_spi_rx_pkg.sv
// Shared types and helpers for the SPI master receive sequencer.
package prvp_spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } rx_seq_state_e;

    localparam int WORD_W     = 32;
    localparam int WORD_SHIFT = 5;

    // Number of 32-bit words needed to hold len bits (ceil(len/32)).
    function automatic logic [31:0] words_for_len(input logic [31:0] len);
        return (len + 32'(WORD_W - 1)) >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/prvp_spi_master_rx_seq.sv
// Receive transaction sequencer: takes one read command, loads the RX
// datapath length, enables reception and forwards words downstream with a
// last marker. The word path is a zero-latency pass-through, so downstream
// backpressure stalls the datapath directly.
module prvp_spi_master_rx_seq
    import prvp_spi_rx_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_quad,
    output logic              rx_en,
    output logic              rx_quad,
    output logic [LEN_W-1:0]  rx_len,
    output logic              rx_len_upd,
    input  logic              rx_done_i,
    input  logic [WORD_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              xfer_done,
    output logic              cmd_err
);

    // Word counters: 2048 words max at LEN_W=16 fits in LEN_W-4 bits.
    localparam int CW = LEN_W - 4;

    rx_seq_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             quad_q, quad_d;
    logic [CW-1:0]    words_q, words_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             err_q, err_d;
    // Held low through reset so cmd_ready (and every output) is 0 while in reset.
    logic             rdy_q;

    logic run, hs, cmd_bad;

    assign run       = (state_q == RUN);
    assign out_valid = run && rx_valid_i;
    assign rx_ready_o = run && out_ready;
    assign out_data  = run ? rx_data_i : '0;
    assign out_last  = out_valid && (cnt_q == words_q - CW'(1));
    assign hs        = out_valid && out_ready;

    // Zero length, or a quad length that is not a whole number of nibbles.
    assign cmd_bad   = (cmd_len == '0) || (cmd_quad && (cmd_len[1:0] != 2'b00));

    assign cmd_ready  = rdy_q && (state_q == IDLE);
    assign rx_en      = run && !seen_q;
    assign rx_len     = len_q;
    assign rx_quad    = quad_q;
    assign rx_len_upd = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign xfer_done  = (state_q == FINISH);
    assign cmd_err    = err_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            quad_q  <= 1'b0;
            words_q <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            quad_q  <= quad_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    // Next-state: command intake, length load, word counting, completion.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        quad_d  = quad_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = cmd_len;
                        quad_d  = cmd_quad;
                        words_d = CW'(words_for_len(32'(cmd_len)));
                        cnt_d   = '0;
                        seen_d  = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (rx_done_i) seen_d = 1'b1;
                if (hs) begin
                    cnt_d = cnt_q + CW'(1);
                    if (out_last) state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prvp_spi_master_rx_seq.sv
// Directed bench for the RX sequencer; the bench plays the RX datapath and
// the downstream consumer.
module tb_prvp_spi_master_rx_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic        cmd_quad;
    logic        rx_en;
    logic        rx_quad;
    logic [15:0] rx_len;
    logic        rx_len_upd;
    logic        rx_done_i;
    logic [31:0] rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        xfer_done;
    logic        cmd_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prvp_spi_master_rx_seq #(.LEN_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_quad(cmd_quad),
        .rx_en(rx_en), .rx_quad(rx_quad), .rx_len(rx_len), .rx_len_upd(rx_len_upd),
        .rx_done_i(rx_done_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .rx_ready_o(rx_ready_o),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy), .xfer_done(xfer_done), .cmd_err(cmd_err)
    );

    typedef struct {
        logic [15:0] len;
        logic        quad;
        logic        err;       // command must be rejected
        int          words;     // expected word count
        int          stall_at;  // word index to hold out_ready low at (-1 none)
        int          stall_n;   // cycles of backpressure
        logic        early;     // rx_done_i in a bubble before the last word
    } vec_t;

    vec_t vt[9];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int tag, input int k);
        return 32'hA500_0000 | (32'(tag) << 16) | 32'(k);
    endfunction

    task automatic chk_all_zero();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rx_en", rx_en, 1'b0);
        chk32("rst_rx_len", 32'(rx_len), 32'd0);
        chk1("rst_rx_quad", rx_quad, 1'b0);
        chk1("rst_len_upd", rx_len_upd, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_rx_ready", rx_ready_o, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk32("rst_out_data", out_data, 32'd0);
        chk1("rst_xfer_done", xfer_done, 1'b0);
        chk1("rst_cmd_err", cmd_err, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
    endtask

    // One command from offer through completion; ends in the xfer_done
    // cycle (or the cmd_err cycle), so a following call offers its command
    // exactly 2 cycles after the last handshake.
    task automatic run_cmd(input vec_t v, input int tag);
        int k;
        int stalled;
        logic done_sent;
        logic [31:0] d;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = v.len; cmd_quad = v.quad;
        #1;
        chk1("cmd_ready", cmd_ready, 1'b1);
        chk1("cmd_err_idle", cmd_err, 1'b0);
        chk1("busy_idle", busy, 1'b0);
        chk1("xfer_done_idle", xfer_done, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_len = '0; cmd_quad = 1'b0;
        #1;
        if (v.err) begin
            chk1("cmd_err", cmd_err, 1'b1);
            chk1("err_busy", busy, 1'b0);
            chk1("err_len_upd", rx_len_upd, 1'b0);
            chk1("err_cmd_ready", cmd_ready, 1'b1);
            return;
        end
        chk1("len_upd", rx_len_upd, 1'b1);
        chk32("rx_len", 32'(rx_len), 32'(v.len));
        chk1("rx_quad", rx_quad, v.quad);
        chk1("en_in_load", rx_en, 1'b0);
        chk1("busy_load", busy, 1'b1);
        k = 0; stalled = 0; done_sent = 1'b0;
        while (k < v.words) begin
            @(negedge clk);
            rx_done_i = 1'b0;
            d = mk(tag, k);
            if (v.early && !done_sent && k == v.words - 1) begin
                rx_valid_i = 1'b0; rx_done_i = 1'b1; out_ready = 1'b1;
                #1;
                chk1("bubble_en", rx_en, 1'b1);
                chk1("bubble_valid", out_valid, 1'b0);
                done_sent = 1'b1;
                continue;
            end
            rx_valid_i = 1'b1; rx_data_i = d;
            if (k == v.stall_at && stalled < v.stall_n) begin
                out_ready = 1'b0; stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (!v.early && k == v.words - 1 && out_ready) rx_done_i = 1'b1;
            #1;
            chk1("rx_en", rx_en, !done_sent);
            chk1("len_upd_run", rx_len_upd, 1'b0);
            chk1("out_valid", out_valid, 1'b1);
            chk32("out_data", out_data, d);
            chk1("rx_ready_o", rx_ready_o, out_ready);
            chk1("out_last", out_last, k == v.words - 1);
            if (out_ready) k++;
        end
        @(negedge clk);
        rx_valid_i = 1'b0; rx_done_i = 1'b0; rx_data_i = '0; out_ready = 1'b1;
        #1;
        chk1("xfer_done", xfer_done, 1'b1);
        chk1("fin_en", rx_en, 1'b0);
        chk1("fin_valid", out_valid, 1'b0);
        chk1("fin_busy", busy, 1'b1);
        chk1("fin_cmd_ready", cmd_ready, 1'b0);
    endtask

    initial begin
        vt[0] = '{16'd32,     1'b0, 1'b0, 1,    -1, 0, 1'b0};
        vt[1] = '{16'd128,    1'b0, 1'b0, 4,    -1, 0, 1'b0};
        vt[2] = '{16'd72,     1'b0, 1'b0, 3,    -1, 0, 1'b1};
        vt[3] = '{16'd64,     1'b1, 1'b0, 2,     1, 5, 1'b0};
        vt[4] = '{16'd0,      1'b0, 1'b1, 0,    -1, 0, 1'b0};
        vt[5] = '{16'd30,     1'b1, 1'b1, 0,    -1, 0, 1'b0};
        vt[6] = '{16'd33,     1'b0, 1'b0, 2,     0, 2, 1'b0};
        vt[7] = '{16'd4,      1'b1, 1'b0, 1,    -1, 0, 1'b0};
        vt[8] = '{16'hFFFF,   1'b0, 1'b0, 2048, -1, 0, 1'b0};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_quad = 1'b0;
        rx_done_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        chk_all_zero();
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) run_cmd(vt[i], i);

        // Reset in the middle of a 4-word transfer, after one word.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 16'd128; cmd_quad = 1'b1;
        #1 chk1("mid_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk1("mid_len_upd", rx_len_upd, 1'b1);
        @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = mk(12, 0); out_ready = 1'b1;
        #1;
        chk1("mid_w0_valid", out_valid, 1'b1);
        chk1("mid_w0_last", out_last, 1'b0);
        @(negedge clk);
        rx_data_i = mk(12, 1);
        #1 chk1("mid_w1_valid", out_valid, 1'b1);
        rstn = 1'b0;
        #1 chk_all_zero();
        rx_valid_i = 1'b0; rx_data_i = '0;
        @(negedge clk);
        rstn = 1'b1;
        run_cmd(vt[0], 13);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
